sync_fifo_nbit: RTL and testbench

Parametrised synchronous FIFO: single clock, single write port, single read port.
- Generalises the team's fixed 8-bit x 1024 SRAM and N-bit register into a buffered queue with occupancy tracking and full/empty handshake.
- Sits between a producer and a consumer in the same clock domain, for example UART byte buffering or key-event queues.

---
 rtl/sync_fifo_nbit_pkg.sv | 14 +
 rtl/sync_fifo_nbit_mem.sv | 42 ++++
 rtl/sync_fifo_nbit.sv | 105 ++++++++++
 tb/tb_sync_fifo_nbit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_nbit_pkg.sv
// Shared FIFO definitions: default geometry and almost-full threshold.
package sync_fifo_nbit_pkg;

  localparam int unsigned DefDataW   = 8;
  localparam int unsigned DefAddrW   = 4;
  localparam int unsigned DefDepth   = 2 ** DefAddrW;
  localparam int unsigned DefAfullTh = 12;

  // Number of words addressed by a pointer of the given width.
  function automatic int unsigned depth_of(int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/sync_fifo_nbit_mem.sv
// Dual-port storage for sync_fifo_nbit: one synchronous write port and one
// registered read port. The array itself is never reset; only the read register is.
module sync_fifo_nbit_mem
  import sync_fifo_nbit_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned Depth = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  // Write port: store the word on an accepted write.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: same-address read during a write returns the old word.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_nbit.sv
// Single-clock FIFO with occupancy count and full/empty/almost-full flags.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is
// defined; otherwise those ports are tied to 0.
module sync_fifo_nbit
  import sync_fifo_nbit_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned AFULL_TH = DefAfullTh
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(depth_of(ADDR_W));
  localparam logic [ADDR_W:0] AfullCnt = (ADDR_W + 1)'(AFULL_TH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_acc, wr_acc;

  // Flags decode the registered count only, so they never glitch mid-cycle.
  assign full        = (count_q == DepthCnt);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AfullCnt);
  assign count       = count_q;

  // A read frees a slot this cycle, so a write at full is still accepted.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  sync_fifo_nbit_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset_p (reset_p),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en & full & ~rd_en) overflow_q  <= 1'b1;
      if (rd_en & empty)         underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_nbit.sv
// Scoreboard bench for sync_fifo_nbit: a queue-based reference model predicts
// accepts, occupancy and flags; expected read words go to a scoreboard queue that
// a separate monitor drains on the negedge after each predicted read.
module tb_sync_fifo_nbit;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFTH  = 12;

  logic          clk = 1'b0;
  logic          reset_p = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          full, empty, almost_full, overflow, underflow;
  logic [AW:0]   count;

  sync_fifo_nbit #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .AFULL_TH(AFTH)
  ) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: contents as a plain queue, sticky error bits.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  bit            m_ovf = 0;
  bit            m_unf = 0;
  bit            rd_fire = 0;
  bit            rd_fire_q = 0;
  logic [DW-1:0] last_exp = '0;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_status(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".afull"}, 32'(almost_full), 32'(n >= AFTH));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
  endtask

  // One clock: drive requests, predict the outcome, check status after the edge.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input string tag);
    bit rd_ok, wr_ok;
    int n;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    n       = model_q.size();
    rd_ok   = r && (n > 0);
    wr_ok   = w && ((n < DEPTH) || rd_ok);
    if (ErrEn && w && (n == DEPTH) && !r) m_ovf = 1;
    if (ErrEn && r && (n == 0)) m_unf = 1;
    rd_fire = rd_ok;
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    @(posedge clk);
    #1;
    chk_status(tag);
  endtask

  always @(posedge clk or posedge reset_p) begin
    if (reset_p) rd_fire_q <= 1'b0;
    else         rd_fire_q <= rd_fire;
  end

  // Monitor: rd_data must hold the last predicted word, updated once per read.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_p) begin
        exp_q.delete();
        last_exp = '0;
      end else begin
        if (rd_fire_q) begin
          if (exp_q.size() == 0) chk("sb_underrun", 32'd1, 32'd0);
          else last_exp = exp_q.pop_front();
        end
        chk("rd_data", 32'(rd_data), 32'(last_exp));
      end
    end
  end

  // Asynchronous reset pulse in the middle of a cycle; outputs must clear at once.
  task automatic do_reset(input string tag);
    #2;
    reset_p = 1'b1;
    #1;
    model_q.delete();
    m_ovf   = 0;
    m_unf   = 0;
    rd_fire = 0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    chk_status(tag);
    chk({tag, ".rd_data"}, 32'(rd_data), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_p = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("reset");
    for (int i = 0; i < 3; i++) step(0, '0, 0, "idle");

    // Fill with 0x01..0x10, then drain in order.
    for (int i = 1; i <= DEPTH; i++) step(1, DW'(i), 0, "fill");
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, "drain");

    // Full with simultaneous read/write.
    for (int i = 0; i < DEPTH; i++) step(1, DW'($urandom), 0, "fill2");
    for (int i = 0; i < 4; i++) step(1, 8'hAA, 1, "full_rw");
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, "drain2");

    // Empty with simultaneous read/write: write only, no write-through.
    step(1, 8'h55, 1, "empty_rw");
    step(0, '0, 1, "empty_rw_rd");

    // Pointer wrap.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) step(1, DW'($urandom), 0, "wrap_w");
      for (int i = 0; i < 10; i++) step(0, '0, 1, "wrap_r");
    end

    // Write at full without read, then read at empty.
    for (int i = 0; i < DEPTH; i++) step(1, DW'($urandom), 0, "fill3");
    step(1, 8'hEE, 0, "ovf");
    step(0, '0, 0, "ovf_hold");
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, "drain3");
    step(0, '0, 1, "unf");
    step(1, 8'h33, 0, "unf_hold");
    step(0, '0, 1, "unf_hold_rd");

    // Random traffic, biased differently in phases to visit full and empty.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 150; i++) begin
        int wb, rb;
        wb = (p == 0) ? 75 : (p == 1) ? 30 : 50;
        rb = (p == 0) ? 30 : (p == 1) ? 75 : 50;
        step(($urandom_range(99) < wb), DW'($urandom), ($urandom_range(99) < rb), "rand");
      end
    end

    // Reset mid-transfer, then confirm normal operation afterwards.
    for (int i = 0; i < 6; i++) step(1, DW'($urandom), (i > 2), "pre_rst");
    do_reset("mid_reset");
    for (int i = 0; i < 40; i++) step($urandom_range(1), DW'($urandom), $urandom_range(1), "post_rst");
    for (int i = 0; i < DEPTH + 2; i++) step(0, '0, 1, "final_drain");

    repeat (2) @(posedge clk);
    #1;
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
